seq_fixedpoint_square: RTL
==========================

Name: seq_fixedpoint_square

Overview:
- Multi-cycle signed fixed-point squarer; it is the inverse operation of the library's fixed-point square-root blocks.
- Accepts one signed Q(WII.WIF) operand through a valid/ready handshake.
- Squares it by iterative shift-add, one operand bit per cycle.
- Returns the result in Q(WOI.WOF) format, with the library's round, saturate and flow-flag rules.
- Intended for area-constrained datapaths and as a round-trip checker for the sqrt units.

Parameters:
- WII, 10, input integer bits, sign included.
- WIF, 13, input fractional bits.
- WOI, 13, output integer bits, sign included.
- WOF, 13, output fractional bits.
- ROOF, 1, 1 = saturate on overflow; 0 = wrap by keeping the low bits.
- ROUND, 1, 1 = round half up when discarding fractional bits; 0 = truncate.

Ports:
- rstn  input  1  asynchronous active-low reset.
- clk  input  1  rising-edge clock.
- i_valid  input  1  operand valid.
- i_ready  output  1  block can accept an operand.
- in  input  WII+WIF  signed operand, Q(WII.WIF).
- o_valid  output  1  one-cycle result strobe.
- out  output  WOI+WOF  signed result, Q(WOI.WOF), always >= 0.
- upflow  output  1  result exceeded the output range; qualified by o_valid.
- downflow  output  1  nonzero input produced a zero result; qualified by o_valid.

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-low (rstn); all state on clk rising edge.
  - While rstn=0: state=IDLE; o_valid, out, upflow, downflow all 0.
  - Reset asserted mid-operation aborts the computation with no o_valid.
- Definitions:
  - N = WII+WIF.
  - Magnitude m = |in| as an N-bit unsigned value. The most negative input gives m = 2^(N-1), which is exact.
  - The exact product p = m*m uses 2N bits and carries 2*WIF fractional bits.
- States:
  - IDLE: i_ready=1. On i_valid=1, latch m, clear the accumulator and counter, go to MUL. With i_valid=0, stay in IDLE.
  - MUL: i_ready=0, N cycles. Each cycle, if bit cnt of m is set, add (m << cnt) to the accumulator, then increment cnt. After the cycle with cnt=N-1, go to FMT.
  - FMT: i_ready=0. Rescale p from 2*WIF to WOF fractional bits, register out, upflow, downflow and o_valid=1, go to IDLE.
- Rescaling rules:
  - If WOF >= 2*WIF, left-shift by WOF-2*WIF. Otherwise right-shift by 2*WIF-WOF.
  - With ROUND=1, add bit (2*WIF-WOF-1) of p before the shift (round half up).
- Overflow:
  - upflow=1 if the scaled value > 2^(WOI+WOF-1)-1.
  - With ROOF=1, out = 2^(WOI+WOF-1)-1.
  - With ROOF=0, out = low WOI+WOF bits of the scaled value.
- downflow=1 if in != 0 and the scaled value == 0.
- upflow and downflow are never both 1.
- Latency: accept edge E0; MUL edges E1..EN; results and o_valid registered at edge E(N+1).
- o_valid is high exactly one cycle.
- out, upflow and downflow hold their last values until the next FMT.
- State is IDLE during the o_valid cycle, so i_ready=1. Throughput is one operand per N+2 cycles.
- i_valid and in are ignored while i_ready=0; no buffering.
- i_ready is decoded from the state register; no combinational path from i_valid.
- in is sampled only at the accept edge; later changes have no effect.

Test Plan (defaults: N=23, W_O=26):
- Reset, then in=0x006000 (3.0) with i_valid=1 for one cycle.
  - o_valid exactly 24 cycles after acceptance, out=0x12000 (9.0), upflow=0, downflow=0.
  - i_ready=0 during MUL and FMT.
- in=0x7FB000 (-2.5) -> out=0x0C800 (6.25), flags 0.
- in=0x0C8000 (100.0) with ROOF=1 -> out=0x1FFFFFF, upflow=1.
- in=0x400000 (-512.0) -> upflow=1, no sign error.
- in=0x000001 -> out=0, downflow=1.
- in=0x000041 with ROUND=1 -> out=1, downflow=0. Same input with ROUND=0 -> out=0, downflow=1.
- in=0 -> out=0, downflow=0.
- Hold i_valid=1 with changing in while busy -> only the accepted operands are squared, back-to-back every 25 cycles.
- Drop rstn at cycle 10 of MUL -> outputs 0 immediately, no o_valid. After release, the next operand is computed correctly.
- Random sweep of 2000 operands vs. a reference model, including -2^22, 0 and ±1 LSB -> bit-exact out and flags.

Source files
------------

// File: rtl/seq_fixedpoint_square.sv
// Multi-cycle signed fixed-point squarer, one shift-add per operand bit.
// Q(WII.WIF) in, Q(WOI.WOF) out with rounding, saturation and flow flags.
module seq_fixedpoint_square #(
  parameter int WII   = 10,
  parameter int WIF   = 13,
  parameter int WOI   = 13,
  parameter int WOF   = 13,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_valid,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow
);

  localparam int N   = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int LSH = (WOF >= 2*WIF) ? WOF - 2*WIF : 0;
  localparam int RSH = (WOF >= 2*WIF) ? 0 : 2*WIF - WOF;
  localparam int RB  = (RSH > 0) ? RSH - 1 : 0;
  localparam int SW  = 2*N + LSH + 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FMT
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_m;
  logic [2*N-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;

  logic [N-1:0]    w_mag;
  logic [2*N-1:0]  w_add;
  logic            w_rbit;
  logic [SW-1:0]   w_scaled;
  logic            w_up;
  logic            w_dn;
  logic [WO-1:0]   w_out;

  assign i_ready = (r_state == IDLE);

  // Two's-complement negate; the most negative input maps to 2^(N-1).
  always_comb begin
    w_mag = in[N-1] ? (~in + N'(1)) : in;
  end

  always_comb begin
    w_add = '0;
    if (r_m[r_cnt])
      w_add = (2*N)'(r_m) << r_cnt;
  end

  // Round half up: the first discarded bit is added after the shift.
  always_comb begin
    w_rbit = 1'b0;
    if (ROUND != 0 && RSH > 0)
      w_rbit = r_acc[RB];
    w_scaled = ((SW'(r_acc) << LSH) >> RSH) + SW'(w_rbit);
    w_up     = |(w_scaled >> (WO-1));
    w_dn     = (r_m != '0) && (w_scaled == '0);
    w_out    = WO'(w_scaled);
    if (w_up && ROOF != 0)
      w_out = {1'b0, {(WO-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      o_valid  <= 1'b0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_m     <= w_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc <= r_acc + w_add;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N-1))
            r_state <= FMT;
        end
        FMT: begin
          out      <= w_out;
          upflow   <= w_up;
          downflow <= w_dn;
          o_valid  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
